// File: rtl/intr_ctrl.sv
// intr_ctrl: memory-mapped interrupt controller.
//
// Each source line goes through a 2-flop synchronizer. It is then normalized to
// active-high raw[i] and captured into PENDING. A bit captures either on a
// rising edge of raw (edge mode) or by following raw every cycle (level mode).
// PENDING & ENABLE drives a registered active-low nIRQ. VECTOR gives the
// lowest-numbered active source.
//
// Ports:
//   clk      - single clock, all state updates on its rising edge
//   reset    - synchronous, active-high
//   CS_N     - chip select, active low
//   RD_N     - read strobe, active low
//   WR_N     - write strobe, active low
//   Addr     - byte address; Addr[4:2] selects a register, Addr[11:5] must be 0
//   DataIn   - write data
//   DataOut  - registered read data (holds between reads)
//   irq_src  - asynchronous interrupt source lines
//   nIRQ     - registered interrupt request, active low
//
// Register map (word offsets):
//   0x00 RAW (RO), 0x04 PENDING (RO), 0x08 ENABLE (RW), 0x0C EDGE_SEL (RW),
//   0x10 CLEAR (WO, W1C), 0x14 SOFT_SET (WO, W1S), 0x18 VECTOR (RO)
module intr_ctrl #(
  parameter int NSRC           = 8,
  parameter bit SRC_ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            CS_N,
  input  logic            RD_N,
  input  logic            WR_N,
  input  logic [11:0]     Addr,
  input  logic [31:0]     DataIn,
  output logic [31:0]     DataOut,
  input  logic [NSRC-1:0] irq_src,
  output logic            nIRQ
);

  localparam logic [2:0] A_RAW      = 3'd0;
  localparam logic [2:0] A_PENDING  = 3'd1;
  localparam logic [2:0] A_ENABLE   = 3'd2;
  localparam logic [2:0] A_EDGE_SEL = 3'd3;
  localparam logic [2:0] A_CLEAR    = 3'd4;
  localparam logic [2:0] A_SOFT_SET = 3'd5;
  localparam logic [2:0] A_VECTOR   = 3'd6;

  // Synchronizers reset to the electrically inactive level, so a source that
  // is held asserted through reset shows up as a fresh edge after release.
  localparam logic [NSRC-1:0] SRC_IDLE = {NSRC{SRC_ACTIVE_LOW}};

  logic [NSRC-1:0] sync1;
  logic [NSRC-1:0] sync2;
  logic [NSRC-1:0] raw;
  logic [NSRC-1:0] raw_d;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] edge_sel;
  logic [NSRC-1:0] active;
  logic [NSRC-1:0] pending_nxt;
  logic [NSRC-1:0] wdata;
  logic [31:0]     vector;
  logic [31:0]     rd_data;
  logic            hit;
  logic            rd_en;
  logic            wr_en;
  logic            wr_enable;
  logic            wr_edge_sel;
  logic            wr_clear;
  logic            wr_soft_set;
  logic            unused_bits;

  // Widen an NSRC-bit register to the 32-bit bus with zero upper bits.
  function automatic logic [31:0] zext(input logic [NSRC-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[NSRC-1:0] = v;
    return r;
  endfunction

  assign raw         = SRC_ACTIVE_LOW ? ~sync2 : sync2;
  assign active      = pending & enable;
  assign wdata       = DataIn[NSRC-1:0];
  assign hit         = ~CS_N & (Addr[11:5] == 7'd0);
  assign rd_en       = ~CS_N & ~RD_N;
  assign wr_en       = hit & ~WR_N;
  assign wr_enable   = wr_en & (Addr[4:2] == A_ENABLE);
  assign wr_edge_sel = wr_en & (Addr[4:2] == A_EDGE_SEL);
  assign wr_clear    = wr_en & (Addr[4:2] == A_CLEAR);
  assign wr_soft_set = wr_en & (Addr[4:2] == A_SOFT_SET);
  // Byte-lane bits and data bits above NSRC are intentionally ignored.
  assign unused_bits = ^{Addr[1:0], DataIn};

  // Priority encoder: lowest-numbered active source, valid flag in bit 31.
  always_comb begin
    vector = 32'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        vector = {1'b1, 26'd0, 5'(i)};
      end else begin
        vector = vector;
      end
    end
  end

  // Next PENDING.
  // Edge bits hold their value, CLEAR knocks bits down, and a set wins over
  // CLEAR. Level bits simply mirror raw. Any bit whose mode changes is cleared.
  always_comb begin
    logic [NSRC-1:0] set_bits;
    logic [NSRC-1:0] clr_bits;
    logic [NSRC-1:0] mode_chg;
    set_bits = (raw & ~raw_d) | (wr_soft_set ? wdata : {NSRC{1'b0}});
    clr_bits = wr_clear ? wdata : {NSRC{1'b0}};
    mode_chg = wr_edge_sel ? (wdata ^ edge_sel) : {NSRC{1'b0}};
    pending_nxt = ((edge_sel & ((pending & ~clr_bits) | set_bits)) |
                   (~edge_sel & raw)) & ~mode_chg;
  end

  // Read mux; unmapped, write-only and out-of-window addresses read as 0.
  always_comb begin
    rd_data = 32'd0;
    if (hit) begin
      case (Addr[4:2])
        A_RAW:      rd_data = zext(raw);
        A_PENDING:  rd_data = zext(pending);
        A_ENABLE:   rd_data = zext(enable);
        A_EDGE_SEL: rd_data = zext(edge_sel);
        A_VECTOR:   rd_data = vector;
        default:    rd_data = 32'd0;
      endcase
    end else begin
      rd_data = 32'd0;
    end
  end

  // All state: synchronizers, edge history, registers, read data and nIRQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= SRC_IDLE;
      sync2    <= SRC_IDLE;
      raw_d    <= {NSRC{1'b0}};
      pending  <= {NSRC{1'b0}};
      enable   <= {NSRC{1'b0}};
      edge_sel <= {NSRC{1'b0}};
      DataOut  <= 32'd0;
      nIRQ     <= 1'b1;
    end else begin
      sync1   <= irq_src;
      sync2   <= sync1;
      raw_d   <= raw;
      pending <= pending_nxt;
      if (wr_enable) begin
        enable <= wdata;
      end
      if (wr_edge_sel) begin
        edge_sel <= wdata;
      end
      // Reads sample the pre-update register values.
      if (rd_en) begin
        DataOut <= rd_data;
      end
      nIRQ <= ~|active;
    end
  end

endmodule
